decode_scan: RTL and testbench
==============================

DECODE_SCAN -- requirements
Module: decode_scan

Interface
REQ-001 SHALL provide parameter N, default 3: index width, legal range 1..6.
REQ-002 SHALL provide parameter DIV, default 4: clock cycles per scan step, legal range 1..65535.
REQ-003 SHALL derive local parameter OUT_W = 2**N as the output width.
REQ-004 SHALL provide port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL provide port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL provide port en, input, 1 bit: block enable.
REQ-007 SHALL provide port mode, input, 1 bit: 0 = DIRECT, 1 = SCAN.
REQ-008 SHALL provide port x, input, N bits: the index decoded in DIRECT mode.
REQ-009 SHALL provide port last, input, N bits: the highest index visited in SCAN mode.
REQ-010 SHALL provide port y, output, OUT_W bits: registered one-hot decode.
REQ-011 SHALL provide port idx, output, N bits: the index currently driven on y.
REQ-012 SHALL provide port valid, output, 1 bit: high when y carries an active line.
REQ-013 SHALL provide port tick, output, 1 bit: one-cycle pulse on each scan advance.

Function
REQ-014 SHALL implement a three-state FSM {IDLE, DIRECT, SCAN}; the next state is evaluated every cycle: en=0 -> IDLE; en=1, mode=0 -> DIRECT; en=1, mode=1 -> SCAN.
REQ-015 SHALL register every output; no combinational path from any input to any output.
REQ-016 In IDLE, SHALL drive y=0, idx=0, valid=0 and tick=0, and SHALL clear the cycle counter.
REQ-017 In DIRECT, SHALL apply 1-cycle latency: x sampled at edge k appears as y = 1<<x, idx = x, valid=1 after edge k.
REQ-018 In DIRECT, SHALL hold the cycle counter at 0 and tick at 0.
REQ-019 On entry to SCAN from IDLE or DIRECT, SHALL set idx=0, y=1, valid=1 and cycle counter=0 on the entry edge.
REQ-020 In SCAN, SHALL increment the counter every cycle; at counter=DIV-1 it SHALL wrap to 0, advance idx and pulse tick for exactly that cycle.
REQ-021 The scan advance SHALL be: idx >= last -> idx = 0; otherwise idx = idx + 1.
REQ-022 Consequence of REQ-021: last=0 keeps idx at 0 but tick still pulses every DIV cycles.
REQ-023 Consequence of REQ-021: lowering last below the current idx mid-scan wraps idx to 0 on the next advance.
REQ-024 With DIV=1, SHALL advance idx on every cycle in SCAN, with tick continuously high.
REQ-025 A SCAN -> DIRECT switch SHALL take effect on the next edge: y = 1<<x, the counter cleared, no tick.
REQ-026 A DIRECT -> SCAN switch SHALL restart the scan at idx 0 per REQ-019.
REQ-027 Deasserting en in any state SHALL reach IDLE outputs on the next edge.
REQ-028 SHALL drive y with exactly one bit active whenever valid=1, and no bit active whenever valid=0.
REQ-029 SHALL size the cycle counter to ceil(log2(DIV)) bits, minimum 1, and it SHALL never exceed DIV-1.

Reset
REQ-030 When rst=1 at a rising edge, SHALL force state IDLE, y=0, idx=0, valid=0, tick=0, counter=0, regardless of en and mode.
REQ-031 rst SHALL take priority over all other inputs, including mid-scan.
REQ-032 On the first edge after rst falls, SHALL resume per REQ-014.
REQ-033 SHALL not use any asynchronous reset or set.

Configuration
REQ-034 When macro DECODE_ACTIVE_LOW_EN is defined, SHALL drive y bitwise inverted: IDLE/reset y = all ones, active line = 0.
REQ-035 When DECODE_ACTIVE_LOW_EN is defined, idx, valid and tick SHALL keep their active-high behaviour.
REQ-036 When DECODE_ACTIVE_LOW_EN is undefined, SHALL drive y active-high per REQ-016 to REQ-030.

Verification
REQ-037 Reset: hold rst=1 with en=1, mode=1 for 3 cycles -> y=0x00, idx=0, valid=0, tick=0 throughout.
REQ-038 Direct sweep (N=3): en=1, mode=0, x=0..7 one per cycle -> y=0x01..0x80 one cycle later, valid=1.
REQ-039 Scan wrap (N=3, DIV=4, last=5): en=1, mode=1 for 30 cycles -> idx sequence 0,1,2,3,4,5,0,... each held 4 cycles; tick pulses every 4th cycle.
REQ-040 Mid-scan change: idx=6 with last=7, set last=2 -> next advance gives idx=0, y=0x01.
REQ-041 Disruptions: drop en mid-scan -> next cycle y=0x00, valid=0; separately, assert rst at counter=2 -> all outputs 0 next edge, and scan restarts at idx 0 after release.
REQ-042 Active-low build with DECODE_ACTIVE_LOW_EN (N=3): reset -> y=0xFF; direct x=3 -> y=0xF7, valid=1.

Source files
------------

// File: rtl/decode_scan.sv
// -----------------------------------------------------------------------------
// decode_scan
// Registered one-hot decoder with two sources for the active line: a directly
// supplied index, or an internal scan that steps through indices 0..last,
// advancing once every DIV clock cycles.
//
// Parameters
//   N     index width (1..6)
//   DIV   clock cycles per scan step (1..65535)
//   OUT_W derived output width, 2**N
//
// Ports
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   en     block enable; low forces the IDLE outputs on the next edge
//   mode   0 = DIRECT (decode x), 1 = SCAN (walk 0..last)
//   x      index decoded in DIRECT mode
//   last   highest index visited in SCAN mode
//   y      registered one-hot decode
//   idx    index currently driven on y
//   valid  high when y carries an active line
//   tick   one-cycle pulse on each scan advance
//
// Build option
//   DECODE_ACTIVE_LOW_EN  when defined, y is driven bitwise inverted (idle and
//                         reset give all ones, the active line is 0); idx,
//                         valid and tick remain active-high.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | disabled or in reset; outputs cleared, counter cleared
// DIRECT | y decodes x with one cycle of latency; counter held at 0
// SCAN   | counter runs modulo DIV; idx steps 0..last on each wrap
// -----------------------------------------------------------------------------
module decode_scan #(
   parameter int N   = 3,
   parameter int DIV = 4,
   localparam int OUT_W = 2 ** N
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mode,
   input  logic [N-1:0]     x,
   input  logic [N-1:0]     last,
   output logic [OUT_W-1:0] y,
   output logic [N-1:0]     idx,
   output logic             valid,
   output logic             tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0]    CNT_LAST = CW'(DIV - 1);
   localparam logic [OUT_W-1:0] ONE_HOT0 = OUT_W'(1);

`ifdef DECODE_ACTIVE_LOW_EN
   localparam logic [OUT_W-1:0] Y_IDLE = '1;
`else
   localparam logic [OUT_W-1:0] Y_IDLE = '0;
`endif

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DIRECT = 2'd1,
      S_SCAN   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [N-1:0]     idx_q, idx_d;
   logic             valid_q, valid_d;
   logic             tick_q, tick_d;
   logic [OUT_W-1:0] y_q, y_d;
   logic [OUT_W-1:0] y_hot;

   // Outputs are computed for the state being entered, so every output is
   // registered and changes on the same edge as the state.
   always_comb begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      valid_d = 1'b0;
      tick_d  = 1'b0;

      if (!en) begin
         state_d = S_IDLE;
      end else if (!mode) begin
         state_d = S_DIRECT;
      end else begin
         state_d = S_SCAN;
      end

      case (state_d)
         S_DIRECT: begin
            idx_d   = x;
            valid_d = 1'b1;
         end
         S_SCAN: begin
            valid_d = 1'b1;
            // Entering from IDLE or DIRECT restarts at index 0 with a fresh
            // counter; only a SCAN -> SCAN cycle counts and advances.
            if (state_q == S_SCAN) begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d  = '0;
                  tick_d = 1'b1;
                  // >= rather than == so a last lowered below the current
                  // index wraps on the next advance instead of running on.
                  idx_d  = (idx_q >= last) ? '0 : idx_q + N'(1);
               end else begin
                  cnt_d = cnt_q + CW'(1);
                  idx_d = idx_q;
               end
            end
         end
         default: ;
      endcase

      y_hot = valid_d ? (ONE_HOT0 << idx_d) : '0;
`ifdef DECODE_ACTIVE_LOW_EN
      y_d = ~y_hot;
`else
      y_d = y_hot;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         tick_q  <= 1'b0;
         y_q     <= Y_IDLE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         tick_q  <= tick_d;
         y_q     <= y_d;
      end
   end

   assign y     = y_q;
   assign idx   = idx_q;
   assign valid = valid_q;
   assign tick  = tick_q;

endmodule

// File: tb/tb_decode_scan.sv
module tb_decode_scan;

   localparam int N     = 3;
   localparam int DIV   = 4;
   localparam int OUT_W = 8;

   logic             clk = 1'b0;
   logic             rst, en, mode;
   logic [N-1:0]     x, last;
   logic [OUT_W-1:0] y;
   logic [N-1:0]     idx;
   logic             valid, tick;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: which activity the block is in (0 idle, 1 direct,
   // 2 scan), how many cycles have elapsed since the scan was entered, and
   // the expected outputs.
   int           m_act;
   int           m_k;
   int           m_idx;
   logic         m_valid, m_tick;

   decode_scan #(.N(N), .DIV(DIV)) dut (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .mode  (mode),
      .x     (x),
      .last  (last),
      .y     (y),
      .idx   (idx),
      .valid (valid),
      .tick  (tick)
   );

   always #5 clk = ~clk;

   function automatic logic [OUT_W-1:0] y_of(input logic v, input int i);
      logic [OUT_W-1:0] r;
      r = v ? OUT_W'(2 ** i) : '0;
`ifdef DECODE_ACTIVE_LOW_EN
      r = ~r;
`endif
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input logic r, input logic e, input logic m,
                             input logic [N-1:0] xv, input logic [N-1:0] lv);
      if (r || !e) begin
         m_act = 0; m_idx = 0; m_valid = 0; m_tick = 0; m_k = 0;
      end else if (!m) begin
         m_act = 1; m_idx = int'(xv); m_valid = 1; m_tick = 0; m_k = 0;
      end else if (m_act != 2) begin
         m_act = 2; m_idx = 0; m_valid = 1; m_tick = 0; m_k = 0;
      end else begin
         m_k++;
         m_tick = (m_k % DIV) == 0;
         if (m_tick) m_idx = (m_idx >= int'(lv)) ? 0 : m_idx + 1;
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".y"},     32'(y),     32'(y_of(m_valid, m_idx)));
      chk({tag, ".idx"},   32'(idx),   32'(m_idx));
      chk({tag, ".valid"}, 32'(valid), 32'(m_valid));
      chk({tag, ".tick"},  32'(tick),  32'(m_tick));
   endtask

   task automatic cycle(input string tag, input logic r, input logic e, input logic m,
                        input logic [N-1:0] xv, input logic [N-1:0] lv);
      rst = r; en = e; mode = m; x = xv; last = lv;
      @(posedge clk);
      model_edge(r, e, m, xv, lv);
      #1;
      check_model(tag);
   endtask

   initial begin
      logic       r_r, r_e, r_m;
      logic [2:0] r_x, r_l;
      bit         hit;
      m_act = 0; m_k = 0; m_idx = 0; m_valid = 0; m_tick = 0;
      rst = 1; en = 1; mode = 1; x = '0; last = '0;

      // Reset held with en=1, mode=1: everything stays cleared.
      for (int i = 0; i < 3; i++) begin
         cycle("reset", 1, 1, 1, 3'd0, 3'd5);
         chk("reset.y_const", 32'(y), 32'(y_of(0, 0)));
         chk("reset.valid_const", 32'(valid), 0);
      end

      // Direct sweep: one-hot of x one cycle later.
      for (int i = 0; i < 8; i++) begin
         cycle("direct", 0, 1, 0, 3'(i), 3'd5);
         chk("direct.y_const", 32'(y), 32'(y_of(1, i)));
      end

      // Scan wrap with last=5: each index held DIV cycles, tick on advance.
      for (int c = 0; c < 30; c++) begin
         cycle("scan", 0, 1, 1, 3'd0, 3'd5);
         chk("scan.idx_seq", 32'(idx), 32'((c / 4) % 6));
         chk("scan.tick_seq", 32'(tick), 32'((c > 0) && (c % 4 == 0)));
      end

      // Raise last to 7 and run to idx 6, then lower last to 2.
      hit = 0;
      for (int i = 0; i < 100 && !hit; i++) begin
         cycle("scan7", 0, 1, 1, 3'd0, 3'd7);
         hit = (idx == 3'd6);
      end
      chk("midscan.reach6", 32'(hit), 1);
      hit = 0;
      for (int i = 0; i < 10 && !hit; i++) begin
         cycle("scan2", 0, 1, 1, 3'd0, 3'd2);
         hit = tick;
      end
      chk("midscan.tick_seen", 32'(hit), 1);
      chk("midscan.idx0", 32'(idx), 0);
      chk("midscan.y01", 32'(y), 32'(y_of(1, 0)));

      // Drop en mid-scan.
      cycle("en_drop", 0, 0, 1, 3'd0, 3'd2);
      chk("en_drop.y", 32'(y), 32'(y_of(0, 0)));
      chk("en_drop.valid", 32'(valid), 0);

      // Re-enter scan, reset when the counter reaches 2.
      cycle("reenter", 0, 1, 1, 3'd0, 3'd5);
      cycle("cnt1", 0, 1, 1, 3'd0, 3'd5);
      cycle("cnt2", 0, 1, 1, 3'd0, 3'd5);
      cycle("rst_mid", 1, 1, 1, 3'd0, 3'd5);
      chk("rst_mid.y", 32'(y), 32'(y_of(0, 0)));
      chk("rst_mid.idx", 32'(idx), 0);
      chk("rst_mid.tick", 32'(tick), 0);
      cycle("restart", 0, 1, 1, 3'd0, 3'd5);
      chk("restart.idx", 32'(idx), 0);
      chk("restart.y", 32'(y), 32'(y_of(1, 0)));
      chk("restart.valid", 32'(valid), 1);

      // Randomized traffic against the model.
      r_m = 1; r_l = 3'd4;
      for (int i = 0; i < 400; i++) begin
         r_r = ($urandom_range(0, 39) == 0);
         r_e = ($urandom_range(0, 14) != 0);
         if ($urandom_range(0, 24) == 0) r_m = ~r_m;
         if ($urandom_range(0, 19) == 0) r_l = 3'($urandom_range(0, 7));
         r_x = 3'($urandom_range(0, 7));
         cycle("rand", r_r, r_e, r_m, r_x, r_l);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
